// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB bus bundle between a master and the register-file slave.
interface apb_regfile_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    sel;
    logic                    enable;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] strobe;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    slverr;
    modport master (output sel, enable, write, addr, wdata, strobe, input ready, rdata, slverr);
    modport slave  (input sel, enable, write, addr, wdata, strobe, output ready, rdata, slverr);
endinterface

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: parametrised APB slave over a register file with wait states,
// byte strobes, read-only registers and PSLVERR; registers exported flat on regs_q.
module apb_regfile_slave #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    apb_regfile_slave_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   wr_d;
    logic [ADDR_WIDTH-1:0]   word_a;
    logic [IW-1:0]           idx;
    logic                    in_range, misaligned, err, we;
    assign word_a     = bus.addr >> LSB;
    assign idx        = word_a[IW-1:0];
    assign in_range   = 32'(word_a) < NUM_REGS;
    assign misaligned = |(bus.addr & ADDR_WIDTH'(NB - 1));
    assign err        = misaligned | ~in_range | (bus.write & in_range & RO_MASK[idx]);
    assign bus.ready  = (state_q == ACCESS) & bus.sel & bus.enable & (cnt_q == 4'd0);
    assign bus.slverr = bus.ready & err;
    assign we         = bus.ready & bus.write & ~err;
    assign bus.rdata  = (bus.ready & ~bus.write & ~err) ? mem_q[idx] : '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (bus.sel & ~bus.enable) begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_STATES);
            end
        end else if (~bus.sel | bus.ready) begin
            state_d = IDLE;
        end else if (bus.enable & (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end
    // merge the strobed byte lanes over the addressed register's current value
    always_comb begin
        wr_d = mem_q[idx];
        for (int b = 0; b < NB; b++)
            if (bus.strobe[b]) wr_d[8*b +: 8] = bus.wdata[8*b +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (we) mem_q[idx] <= wr_d;
        end
    end
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_q[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed and random APB transfers against a word/byte-level model,
// on a WAIT_STATES=2 instance (target 0) and a WAIT_STATES=0 instance (target 1).
module tb_apb_regfile_slave;
    localparam logic [31:0] RV1 = 32'hA5A5_0F0F;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    apb_regfile_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b0 ();
    apb_regfile_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b1 ();
    logic [255:0] regs0, regs1;
    logic         m_sel = 1'b0, m_en = 1'b0, m_wr = 1'b0;
    logic [11:0]  m_addr = '0;
    logic [31:0]  m_wd = '0;
    logic [3:0]   m_st = '0;
    int           tgt = 0;
    int           checks = 0, errors = 0;
    logic [31:0]  mdl [2][8];
    assign b0.sel = m_sel & (tgt == 0);
    assign b0.enable = m_en & (tgt == 0);
    assign b0.write = m_wr;
    assign b0.addr = m_addr;
    assign b0.wdata = m_wd;
    assign b0.strobe = m_st;
    assign b1.sel = m_sel & (tgt == 1);
    assign b1.enable = m_en & (tgt == 1);
    assign b1.write = m_wr;
    assign b1.addr = m_addr;
    assign b1.wdata = m_wd;
    assign b1.strobe = m_st;
    logic        rdy, serr;
    logic [31:0] rdt;
    assign rdy  = tgt == 1 ? b1.ready : b0.ready;
    assign serr = tgt == 1 ? b1.slverr : b0.slverr;
    assign rdt  = tgt == 1 ? b1.rdata : b0.rdata;
    apb_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(8), .WAIT_STATES(2),
                        .RO_MASK(8'h80), .RESET_VAL(32'h0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .regs_q(regs0));
    apb_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(8), .WAIT_STATES(0),
                        .RO_MASK(8'h80), .RESET_VAL(RV1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .regs_q(regs1));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mdl[0][i] = 32'h0;
            mdl[1][i] = RV1;
        end
    endtask
    task automatic check_regs(input int t);
        for (int i = 0; i < 8; i++)
            chk($sformatf("regs_q[%0d][%0d]", t, i), t == 1 ? regs1[i*32 +: 32] : regs0[i*32 +: 32], mdl[t][i]);
    endtask
    task automatic xfer(input int t, input bit w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int ws, n, idx;
        bit e;
        logic [31:0] er;
        ws = t == 1 ? 0 : 2;
        idx = int'(a) / 4;
        e = (a % 4 != 0) || idx >= 8 || (w && idx == 7);
        er = 32'h0;
        if (!w && !e) er = mdl[t][idx];
        tgt = t; m_sel = 1'b1; m_en = 1'b0; m_wr = w; m_addr = a; m_wd = d; m_st = s;
        @(posedge clk); #1;
        m_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 20) begin
            chk("wait_rdata", rdt, 0);
            chk("wait_slverr", serr, 0);
            n++;
            @(negedge clk);
        end
        chk($sformatf("ready_cycles a=%h", a), n, ws);
        chk($sformatf("slverr a=%h w=%0d", a, w), serr, e);
        chk($sformatf("rdata a=%h w=%0d", a, w), rdt, er);
        @(posedge clk); #1;
        if (w && !e)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[t][idx][8*b +: 8] = d[8*b +: 8];
        m_sel = 1'b0; m_en = 1'b0;
        check_regs(t);
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", rdy, 0);
        chk("reset_rdata", rdt, 0);
        chk("reset_slverr", serr, 0);
        check_regs(0);
        check_regs(1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // wait-state write/read, byte strobes
        xfer(0, 1'b1, 12'h008, 32'hDEADBEEF, 4'hF);
        chk("word2_write", regs0[64 +: 32], 32'hDEADBEEF);
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0);
        xfer(0, 1'b1, 12'h008, 32'h11223344, 4'b0101);
        chk("word2_strobe", regs0[64 +: 32], 32'hDE22BE44);
        xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'b0000);
        chk("word2_nostrobe", regs0[64 +: 32], 32'hDE22BE44);
        // error responses
        xfer(0, 1'b1, 12'h01C, 32'hCAFEF00D, 4'hF);
        xfer(0, 1'b0, 12'h020, 32'h0, 4'hF);
        xfer(0, 1'b1, 12'h005, 32'h55555555, 4'hF);
        xfer(0, 1'b0, 12'h01C, 32'h0, 4'h0);
        // master abort during the second wait cycle
        tgt = 0; m_sel = 1'b1; m_en = 1'b0; m_wr = 1'b1; m_addr = 12'h000; m_wd = 32'h12345678; m_st = 4'hF;
        @(posedge clk); #1;
        m_en = 1'b1;
        @(posedge clk); #1;
        m_sel = 1'b0; m_en = 1'b0;
        @(negedge clk);
        chk("abort_ready", rdy, 0);
        @(posedge clk); #1;
        check_regs(0);
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0);
        // enable without setup phase while idle
        m_sel = 1'b1; m_en = 1'b1; m_wr = 1'b1; m_addr = 12'h004; m_wd = 32'h87654321; m_st = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("idle_enable_ready", rdy, 0);
        end
        @(posedge clk); #1;
        m_sel = 1'b0; m_en = 1'b0;
        check_regs(0);
        // back-to-back on the zero-wait instance
        xfer(1, 1'b1, 12'h000, 32'h0000_1111, 4'hF);
        xfer(1, 1'b1, 12'h004, 32'h0000_2222, 4'hF);
        xfer(1, 1'b1, 12'h008, 32'h0000_3333, 4'hF);
        chk("b2b_w0", regs1[0 +: 32], 32'h0000_1111);
        chk("b2b_w1", regs1[32 +: 32], 32'h0000_2222);
        chk("b2b_w2", regs1[64 +: 32], 32'h0000_3333);
        // reset in the middle of a write access
        xfer(0, 1'b1, 12'h004, 32'h0BADF00D, 4'hF);
        tgt = 0; m_sel = 1'b1; m_en = 1'b0; m_wr = 1'b1; m_addr = 12'h00C; m_wd = 32'h77777777; m_st = 4'hF;
        @(posedge clk); #1;
        m_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_ready", rdy, 0);
        chk("midreset_slverr", serr, 0);
        check_regs(0);
        check_regs(1);
        m_sel = 1'b0; m_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 12'h004, 32'h0, 4'hF);
        // random traffic on both instances
        for (int k = 0; k < 120; k++) begin
            int t;
            logic [11:0] a;
            t = int'($urandom_range(0, 1));
            a = 12'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 5) == 0) a = a | 12'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = 12'hFFC;
            xfer(t, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
